playfield_ram_arbiter: RTL and testbench

- Owns the single port of the Tetris playfield RAM (10×20 cells, 3-bit colour code per cell).
- Shares that port between three clients:
  - the VGA scan-out reader, which has fixed top priority and no stalls;
  - a built-in clear-all sequencer;
  - two game-side requesters (piece logic, line-clear logic), served round-robin.
- Sits between the VGA colour-generation path and the game core, so the displayed board and the game state use one memory.

---
 rtl/playfield_ram_arbiter.sv | 135 +++++++++++++
 tb/tb_playfield_ram_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/playfield_ram_arbiter.sv
// Single-port arbiter for the 10x20 Tetris playfield RAM. Video reads have top
// priority, then the clear-all sequencer, then two round-robin game ports.
module playfield_ram_arbiter #(
    parameter int CELLS     = 200,
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 3,
    parameter int CLR_VALUE = 0
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic                  vid_req,
    input  logic [ADDR_W-1:0]     vid_addr,
    output logic [DATA_W-1:0]     vid_rdata,
    output logic                  vid_rvalid,
    input  logic [1:0]            gm_req,
    input  logic [1:0]            gm_we,
    input  logic [2*ADDR_W-1:0]   gm_addr,
    input  logic [2*DATA_W-1:0]   gm_wdata,
    output logic [1:0]            gm_gnt,
    output logic [DATA_W-1:0]     gm_rdata,
    output logic [1:0]            gm_rvalid,
    input  logic                  clr_start,
    output logic                  clr_busy,
    output logic                  clr_done,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic                  ram_we,
    output logic [DATA_W-1:0]     ram_wdata,
    input  logic [DATA_W-1:0]     ram_rdata
);

    localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(CELLS - 1);

    typedef enum logic {IDLE, CLEAR} clr_state_t;

    clr_state_t        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              done_d;
    logic              rr_q;
    logic              rd_oor_q;

    logic [ADDR_W-1:0] port_addr  [2];
    logic [DATA_W-1:0] port_wdata [2];
    logic              win;
    logic              any_gnt;
    logic              win_in_range;

    assign port_addr[0]  = gm_addr[0 +: ADDR_W];
    assign port_addr[1]  = gm_addr[ADDR_W +: ADDR_W];
    assign port_wdata[0] = gm_wdata[0 +: DATA_W];
    assign port_wdata[1] = gm_wdata[DATA_W +: DATA_W];

    // Port ownership: video > clear > game; everything idles to zero in reset.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        gm_gnt       = '0;
        ram_addr     = '0;
        ram_we       = 1'b0;
        ram_wdata    = '0;
        win          = rr_q;
        any_gnt      = 1'b0;
        win_in_range = 1'b0;
        if (!reset) begin
            if (vid_req) begin
                ram_addr = vid_addr;
            end else if (state_q == CLEAR) begin
                ram_addr  = cnt_q;
                ram_we    = 1'b1;
                ram_wdata = DATA_W'(CLR_VALUE);
            end else if (|gm_req) begin
                win          = gm_req[rr_q] ? rr_q : ~rr_q;
                any_gnt      = 1'b1;
                gm_gnt[win]  = 1'b1;
                win_in_range = (port_addr[win] <= LAST_CELL);
                ram_addr     = port_addr[win];
                ram_we       = gm_we[win] & win_in_range;
                ram_wdata    = port_wdata[win];
            end
        end
    end

    // Clear sequencer: the counter advances only on cycles it actually writes.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (clr_start) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                if (!vid_req) begin
                    if (cnt_q == LAST_CELL) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        // NOTE: state registers use non-blocking assignments so all flops update together.
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            clr_done   <= 1'b0;
            rr_q       <= 1'b0;
            rd_oor_q   <= 1'b0;
            vid_rvalid <= 1'b0;
            gm_rvalid  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            clr_done   <= done_d;
            vid_rvalid <= vid_req;
            gm_rvalid  <= gm_gnt & ~gm_we;
            rd_oor_q   <= ~win_in_range;
            if (any_gnt) begin
                rr_q <= ~win;
            end
        end
    end

    assign clr_busy  = (state_q == CLEAR);
    assign vid_rdata = ram_rdata;
    assign gm_rdata  = rd_oor_q ? '0 : ram_rdata;

endmodule

// File: tb/tb_playfield_ram_arbiter.sv
// Randomized bench for playfield_ram_arbiter: a cycle-level ownership model with a
// golden copy of the playfield predicts grants, RAM strobes and all read data.
module tb_playfield_ram_arbiter;

    localparam int CELLS = 200;

    logic       CLOCK_50 = 1'b0;
    logic       reset;
    logic       vid_req;
    logic [7:0] vid_addr;
    logic [2:0] vid_rdata;
    logic       vid_rvalid;
    logic [1:0] gm_req;
    logic [1:0] gm_we;
    logic [15:0] gm_addr;
    logic [5:0] gm_wdata;
    logic [1:0] gm_gnt;
    logic [2:0] gm_rdata;
    logic [1:0] gm_rvalid;
    logic       clr_start;
    logic       clr_busy;
    logic       clr_done;
    logic [7:0] ram_addr;
    logic       ram_we;
    logic [2:0] ram_wdata;
    logic [2:0] ram_rdata;

    logic [2:0] mem [256];

    playfield_ram_arbiter dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .vid_req    (vid_req),
        .vid_addr   (vid_addr),
        .vid_rdata  (vid_rdata),
        .vid_rvalid (vid_rvalid),
        .gm_req     (gm_req),
        .gm_we      (gm_we),
        .gm_addr    (gm_addr),
        .gm_wdata   (gm_wdata),
        .gm_gnt     (gm_gnt),
        .gm_rdata   (gm_rdata),
        .gm_rvalid  (gm_rvalid),
        .clr_start  (clr_start),
        .clr_busy   (clr_busy),
        .clr_done   (clr_done),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Synchronous single-port RAM, one cycle read latency.
    always @(posedge CLOCK_50) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model state.
    int   golden [256];
    bit   m_clearing = 0;
    int   m_next     = 0;
    int   m_prefer   = 0;
    bit   p_vv = 0;
    int   p_vd = 0;
    logic [1:0] p_gv = '0;
    int   p_gd = 0;
    bit   p_done = 0;
    logic [1:0] last_gnt = '0;
    int   done_seen = 0;

    // Game-port requesters (held until granted).
    logic       pr [2];
    logic       pw [2];
    logic [7:0] pa [2];
    logic [2:0] pd [2];

    task automatic apply_ports();
        gm_req   = {pr[1], pr[0]};
        gm_we    = {pw[1], pw[0]};
        gm_addr  = {pa[1], pa[0]};
        gm_wdata = {pd[1], pd[0]};
    endtask

    task automatic set_port(input int p, input logic r, input logic w, input int a, input int d);
        pr[p] = r;
        pw[p] = w;
        pa[p] = 8'(a);
        pd[p] = 3'(d);
    endtask

    task automatic new_req(input int p);
        set_port(p, 1'b1, 1'($urandom_range(0, 1)), $urandom_range(0, 219), $urandom_range(0, 7));
    endtask

    task automatic model_cycle();
        logic [1:0] egnt;
        logic       ewe;
        logic [7:0] eaddr;
        logic [2:0] ewd;
        bit         nvv;
        int         nvd;
        logic [1:0] ngv;
        int         ngd;
        bit         ndone;
        bit         was_clr;
        int         w;
        int         a;
        egnt = '0; ewe = 1'b0; eaddr = '0; ewd = '0;
        nvv = 0; nvd = 0; ngv = '0; ngd = 0; ndone = 0;
        was_clr = m_clearing;
        w = -1;
        a = 0;

        if (clr_done === 1'b1) done_seen++;
        check("clr_busy", 32'(clr_busy), 32'(m_clearing));
        check("clr_done", 32'(clr_done), 32'(p_done));
        check("vid_rvalid", 32'(vid_rvalid), 32'(p_vv));
        if (p_vv) check("vid_rdata", 32'(vid_rdata), p_vd);
        check("gm_rvalid", 32'(gm_rvalid), 32'(p_gv));
        if (p_gv != 0) check("gm_rdata", 32'(gm_rdata), p_gd);

        last_gnt = '0;
        if (reset) begin
            m_clearing = 0;
            m_next     = 0;
            m_prefer   = 0;
        end else begin
            if (vid_req) begin
                eaddr = vid_addr;
                nvv   = 1;
                nvd   = golden[vid_addr];
            end else if (was_clr) begin
                ewe   = 1'b1;
                eaddr = 8'(m_next);
                golden[m_next] = 0;
                m_next++;
                if (m_next == CELLS) begin
                    m_clearing = 0;
                    m_next     = 0;
                    ndone      = 1;
                end
            end else begin
                if (gm_req[m_prefer]) w = m_prefer;
                else if (gm_req[1 - m_prefer]) w = 1 - m_prefer;
                if (w >= 0) begin
                    a = (w == 0) ? int'(gm_addr[7:0]) : int'(gm_addr[15:8]);
                    egnt[w]     = 1'b1;
                    last_gnt[w] = 1'b1;
                    eaddr       = 8'(a);
                    if (gm_we[w]) begin
                        if (a < CELLS) begin
                            ewe = 1'b1;
                            ewd = (w == 0) ? gm_wdata[2:0] : gm_wdata[5:3];
                            golden[a] = int'(ewd);
                        end
                    end else begin
                        ngv[w] = 1'b1;
                        ngd    = (a < CELLS) ? golden[a] : 0;
                    end
                    m_prefer = 1 - w;
                end
            end
            if (!was_clr && clr_start) begin
                m_clearing = 1;
                m_next     = 0;
            end
        end

        check("gm_gnt", 32'(gm_gnt), 32'(egnt));
        check("ram_we", 32'(ram_we), 32'(ewe));
        check("ram_addr", 32'(ram_addr), 32'(eaddr));
        if (ewe) check("ram_wdata", 32'(ram_wdata), 32'(ewd));

        p_vv = nvv; p_vd = nvd; p_gv = ngv; p_gd = ngd; p_done = ndone;
    endtask

    // One clock: inputs already applied, compare at the falling edge, then advance.
    task automatic step();
        apply_ports();
        @(negedge CLOCK_50);
        model_cycle();
        @(posedge CLOCK_50);
        #1;
        for (int p = 0; p < 2; p++) if (last_gnt[p]) pr[p] = 1'b0;
    endtask

    task automatic idle_inputs();
        vid_req = 1'b0; vid_addr = '0; clr_start = 1'b0;
        set_port(0, 1'b0, 1'b0, 0, 0);
        set_port(1, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic video_dump();
        for (int i = 0; i <= CELLS; i++) begin
            vid_req  = (i < CELLS);
            vid_addr = 8'(i % CELLS);
            step();
        end
        vid_req = 1'b0;
    endtask

    task automatic fill(input int base);
        for (int i = 0; i < CELLS; i++) begin
            set_port(0, 1'b1, 1'b1, i, (i + base) % 8);
            step();
        end
        idle_inputs();
        step();
    endtask

    task automatic run_clear_to_end(input bit toggle_vid);
        for (int k = 0; k < 1000 && m_clearing; k++) begin
            vid_req  = toggle_vid ? 1'(k % 2) : 1'($urandom_range(0, 3) == 0);
            vid_addr = 8'($urandom_range(0, CELLS - 1));
            set_port(0, 1'b1, 1'b0, $urandom_range(0, CELLS - 1), 0);
            set_port(1, 1'b1, 1'b1, $urandom_range(0, CELLS - 1), 7);
            step();
        end
        check("clear_finished", 32'(m_clearing), 32'd0);
        idle_inputs();
        repeat (3) step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        idle_inputs();
        apply_ports();
        @(posedge CLOCK_50);
        #1;

        // Reset: grants and writes stay off whatever the inputs do.
        for (int i = 0; i < 3; i++) begin
            vid_req = 1'($urandom_range(0, 1));
            clr_start = 1'b1;
            set_port(0, 1'b1, 1'b1, 5, 3);
            set_port(1, 1'b1, 1'b1, 6, 4);
            step();
        end
        reset = 1'b0;
        idle_inputs();

        // Preload addr%8, then stream the whole board out through video.
        fill(0);
        for (int i = 0; i <= CELLS; i++) begin
            vid_req  = (i < CELLS);
            vid_addr = 8'(i % CELLS);
            set_port(0, 1'b1, 1'b0, 3, 0);
            set_port(1, 1'b1, 1'b0, 4, 0);
            step();
        end
        idle_inputs();

        // Round-robin from a fresh reset: both ports keep requesting reads.
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (!pr[0]) set_port(0, 1'b1, 1'b0, $urandom_range(0, CELLS - 1), 0);
            if (!pr[1]) set_port(1, 1'b1, 1'b0, $urandom_range(0, CELLS - 1), 0);
            step();
        end
        idle_inputs();
        step();

        // Directed write/readback and out-of-range accesses.
        set_port(1, 1'b1, 1'b1, 57, 5);  step();
        set_port(1, 1'b1, 1'b0, 57, 0);  step();
        set_port(0, 1'b1, 1'b1, 220, 6); step();
        set_port(0, 1'b1, 1'b0, 220, 0); step();
        idle_inputs();
        step();
        check("rd57_golden", 32'(golden[57]), 32'd5);

        // Mixed random traffic including occasional clears.
        for (int i = 0; i < 1500; i++) begin
            vid_req   = 1'($urandom_range(0, 3) == 0);
            vid_addr  = 8'($urandom_range(0, CELLS - 1));
            clr_start = 1'($urandom_range(0, 299) == 0);
            for (int p = 0; p < 2; p++) if (!pr[p] && $urandom_range(0, 1) == 1) new_req(p);
            step();
        end
        idle_inputs();
        run_clear_to_end(1'b0);

        // Clear with video on every other cycle, then verify the board is empty.
        fill(3);
        done_seen = 0;
        clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        run_clear_to_end(1'b1);
        check("clr_done_once", 32'(done_seen), 32'd1);
        video_dump();
        for (int i = 0; i < CELLS; i += 37) check("cleared_cell", 32'(golden[i]), 32'd0);

        // Reset while the counter sits at 100: upper half keeps its contents.
        fill(5);
        done_seen = 0;
        clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        for (int k = 0; k < 500 && m_next < 100; k++) begin
            vid_req = 1'($urandom_range(0, 1));
            vid_addr = 8'($urandom_range(0, CELLS - 1));
            step();
        end
        vid_req = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (3) step();
        check("abort_no_done", 32'(done_seen), 32'd0);
        check("abort_cell100", 32'(golden[100]), 32'((100 + 5) % 8));
        video_dump();

        // A second clr_start mid-clear must not restart the sequence.
        done_seen = 0;
        clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        repeat (50) step();
        clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        run_clear_to_end(1'b0);
        check("restart_done_once", 32'(done_seen), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
